mips_dmem_mmio: RTL and testbench
=================================

Name: mips_dmem_mmio

Overview:
- Responder on the data-memory side of the single-cycle MIPS core. It receives the core's memwrite, aluout and writedata, and returns readdata.
- Contains a word-addressed data RAM and a small memory-mapped I/O window:
  - LED register
  - free-running cycle counter
  - byte transmit FIFO with a valid/ready output handshake
  - status register
- Reads are combinational so the single-cycle core closes its load path in one cycle. All writes and state updates occur on the rising clock edge.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of two.
- FIFO_DEPTH, 4, number of transmit FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; rising-edge active
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- memwrite  input  1  write strobe from core
- aluout  input  32  byte address from core
- writedata  input  32  store data from core
- readdata  output  32  load data to core; combinational
- led  output  8  LED register contents
- tx_data  output  8  byte at FIFO head
- tx_valid  output  1  FIFO non-empty
- tx_ready  input  1  downstream accepts tx_data this cycle
- bus_err  output  1  sticky access-error flag

Behaviour:
- Address decode:
  - aluout[1:0] is ignored (word accesses only).
  - aluout[31]=0 selects RAM at word index aluout[log2(RAM_WORDS)+1:2]. Upper bits alias.
  - aluout[31]=1 selects MMIO, decoded on aluout[7:2]:
    - 0x00 LED (RW, bits 7:0)
    - 0x01 CYCLE (RW)
    - 0x02 TXDATA (WO)
    - 0x03 STATUS (R/W1C)
    - any other offset is unmapped.
- RAM: on a clock edge with memwrite=1, writes writedata to the selected word. Reads are asynchronous. Contents are not cleared by reset.
- Read mux:
  - RAM → word contents.
  - LED → {24'b0, led}.
  - CYCLE → counter value.
  - TXDATA → 0.
  - STATUS → {29'b0, overflow, full, empty}.
  - Unmapped → 0.
- LED: loaded with writedata[7:0] on write.
- CYCLE counter:
  - Increments by 1 every cycle; wraps 0xFFFFFFFF → 0.
  - A write loads writedata and takes precedence over the increment; the next cycle reads writedata.
- TX FIFO:
  - Write to TXDATA pushes writedata[7:0] if not full.
  - Pop occurs when tx_valid && tx_ready.
  - tx_valid = !empty. tx_data = head entry, driven from storage and stable while tx_valid=1 && tx_ready=0.
  - Push while empty: tx_valid rises the next cycle; no same-cycle bypass.
  - Push while full with a simultaneous pop: push accepted, count unchanged.
  - Push while full with no pop: byte dropped, overflow set.
  - Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- STATUS:
  - Write with writedata[2]=1 clears overflow.
  - Set and clear in the same cycle (push-drop plus clear write): set wins.
  - Other bits are read-only.
- bus_err: set on any write to an unmapped MMIO offset. Sticky until reset. Unmapped writes have no other effect. Reads never set it.
- Reset (asynchronous assert, synchronous-safe release) sets: led=0, cycle=0, FIFO empty (tx_valid=0), overflow=0, bus_err=0, pointers=0.
  - tx_data after reset is don't-care while tx_valid=0.
  - Reset mid-transfer discards FIFO contents; RAM is unaffected.
- memwrite=0 causes no state change except the counter increment and FIFO pops.

Test Plan:
- Store 0xDEADBEEF to 0x00000010, then load 0x00000010 → readdata 0xDEADBEEF in the same cycle as the address. Load 0x00000110 (alias with RAM_WORDS=64) → 0xDEADBEEF.
- Release reset, wait 10 cycles, read 0x80000004 → 10 (±1 per the sampling edge). Write 0xFFFFFFFE; the next two cycles read 0xFFFFFFFE then 0xFFFFFFFF, then wrap to 0.
- Hold tx_ready=0; push 0x41, 0x42, 0x43, 0x44, 0x45 → STATUS reads 0x6 (full plus overflow) and tx_data=0x41. Raise tx_ready → bytes 41, 42, 43, 44 in order, one per cycle, then tx_valid=0 and STATUS=0x5. Write 0x4 to STATUS → reads 0x1.
- With FIFO full and tx_ready=1, push 0x55 → accepted, overflow stays 0. The drained sequence ends with 0x55.
- Write 0x1234 to 0x80000040 → bus_err=1 and all other state unchanged. Write 0xA5 to 0x80000000 → led=0xA5.
- Pulse reset low mid-drain (tx_valid=1) → immediately tx_valid=0, led=0, bus_err=0, CYCLE=0, while previously written RAM data is still readable.

Source files
------------

// File: rtl/mips_dmem_mmio.sv
// Data-memory responder for the single-cycle MIPS core: word RAM plus an MMIO window
// with an LED register, a free-running cycle counter, a byte transmit FIFO and status.
module mips_dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_err
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  localparam logic [5:0] OFF_LED    = 6'h00;
  localparam logic [5:0] OFF_CYCLE  = 6'h01;
  localparam logic [5:0] OFF_TXDATA = 6'h02;
  localparam logic [5:0] OFF_STATUS = 6'h03;

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [31:0]   cycle;
  logic          overflow;

  logic          is_mmio;
  logic [5:0]    off;
  logic [AW-1:0] ram_idx;
  logic          we_ram, we_led, we_cycle, we_tx, we_status, we_unmapped;
  logic          full, empty, push, pop, drop;

  // Byte-lane bits and the aliased upper address bits are intentionally ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^{aluout[30:8], aluout[1:0]};

  assign is_mmio = aluout[31];
  assign off     = aluout[7:2];
  assign ram_idx = aluout[AW+1:2];

  assign we_ram      = memwrite && !is_mmio;
  assign we_led      = memwrite && is_mmio && (off == OFF_LED);
  assign we_cycle    = memwrite && is_mmio && (off == OFF_CYCLE);
  assign we_tx       = memwrite && is_mmio && (off == OFF_TXDATA);
  assign we_status   = memwrite && is_mmio && (off == OFF_STATUS);
  assign we_unmapped = memwrite && is_mmio && (off > OFF_STATUS);

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign tx_valid = !empty;
  assign tx_data  = fifo_mem[rd_ptr];

  // A full FIFO still takes a push when the head leaves in the same cycle
  assign pop  = tx_valid && tx_ready;
  assign push = we_tx && (!full || pop);
  assign drop = we_tx && full && !pop;

  always_ff @(posedge clk) begin
    if (we_ram) ram[ram_idx] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= writedata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led      <= '0;
      cycle    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      if (we_led) led <= writedata[7:0];
      if (we_cycle) cycle <= writedata;
      else          cycle <= cycle + 32'd1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear leaves the flag set
      if (drop)                           overflow <= 1'b1;
      else if (we_status && writedata[2]) overflow <= 1'b0;
      if (we_unmapped) bus_err <= 1'b1;
    end
  end

  always_comb begin
    readdata = '0;
    if (!is_mmio) begin
      readdata = ram[ram_idx];
    end else begin
      case (off)
        OFF_LED:    readdata = {24'b0, led};
        OFF_CYCLE:  readdata = cycle;
        OFF_STATUS: readdata = {29'b0, overflow, full, empty};
        default:    readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Bench for mips_dmem_mmio: directed scenarios plus randomized traffic against a
// transaction-level model (array RAM, byte queue FIFO, plain counters).
module tb_mips_dmem_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  mips_dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .aluout(aluout),
    .writedata(writedata), .readdata(readdata), .led(led), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [31:0]  m_ram [64];
  bit           m_known [64];
  logic [7:0]   m_led;
  logic [31:0]  m_cycle;
  byte unsigned m_q[$];
  bit           m_ovf;
  bit           m_berr;

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (!a[31]) return m_ram[a[7:2]];
    case (a[7:2])
      6'd0:    return {24'b0, m_led};
      6'd1:    return m_cycle;
      6'd3:    return {29'b0, m_ovf, (m_q.size() == 4), (m_q.size() == 0)};
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit rd_known(input logic [31:0] a);
    return a[31] || m_known[a[7:2]];
  endfunction

  task automatic model_reset();
    m_led = 8'h00; m_cycle = 32'd0; m_q.delete(); m_ovf = 1'b0; m_berr = 1'b0;
  endtask

  task automatic model_update();
    bit pop, full_before, push_req, clr, cyc_wr, drop;
    pop = tx_ready && (m_q.size() > 0);
    full_before = (m_q.size() == 4);
    push_req = 0; clr = 0; cyc_wr = 0;
    if (memwrite) begin
      if (!aluout[31]) begin
        m_ram[aluout[7:2]] = writedata;
        m_known[aluout[7:2]] = 1'b1;
      end else begin
        case (aluout[7:2])
          6'd0:    m_led = writedata[7:0];
          6'd1:    cyc_wr = 1;
          6'd2:    push_req = 1;
          6'd3:    clr = writedata[2];
          default: m_berr = 1'b1;
        endcase
      end
    end
    drop = push_req && full_before && !pop;
    if (pop) void'(m_q.pop_front());
    if (push_req && !drop) m_q.push_back(writedata[7:0]);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_cycle = cyc_wr ? writedata : m_cycle + 32'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_update();
    #1;
  endtask

  task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d);
    memwrite = we; aluout = a; writedata = d;
  endtask

  task automatic test_reset();
    reset = 1'b0; tx_ready = 1'b0;
    bus(1'b0, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (led !== 8'h00) begin n_bad++; $display("FAIL reset_led: got %h want 00", led); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    aluout = 32'h8000_0004; #1;
    n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL reset_cycle: got %h want 0", readdata); end
    aluout = 32'h8000_000C; #1;
    n_cmp++; if (readdata !== 32'h1) begin n_bad++; $display("FAIL reset_status: got %h want 1", readdata); end
    reset = 1'b1;
  endtask

  task automatic test_cycle();
    bus(1'b0, 32'h8000_0004, 32'h0);
    repeat (10) tick();
    n_cmp++; if (readdata !== 32'd10 || readdata !== m_cycle) begin n_bad++; $display("FAIL cycle_count10: got %h want %h", readdata, m_cycle); end
    bus(1'b1, 32'h8000_0004, 32'hFFFF_FFFE);
    tick();
    memwrite = 1'b0; #1;
    n_cmp++; if (readdata !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL cycle_load: got %h want fffffffe", readdata); end
    tick();
    n_cmp++; if (readdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL cycle_inc: got %h want ffffffff", readdata); end
    tick();
    n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL cycle_wrap: got %h want 0", readdata); end
  endtask

  task automatic test_ram();
    logic [31:0] r, a;
    bus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    tick();
    bus(1'b0, 32'h0000_0010, 32'h0); #1;
    n_cmp++; if (readdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_load: got %h want deadbeef", readdata); end
    aluout = 32'h0000_0110; #1;
    n_cmp++; if (readdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_alias: got %h want deadbeef", readdata); end
    for (int i = 0; i < 16; i++) begin
      r = $urandom();
      bus(1'b1, {1'b0, r[30:0]}, $urandom());
      tick();
      r = $urandom();
      a = {1'b0, r[30:8], aluout[7:2], r[1:0]};
      bus(1'b0, a, 32'h0); #1;
      n_cmp++; if (readdata !== exp_rd(a)) begin n_bad++; $display("FAIL ram_rand: addr %h got %h want %h", a, readdata, exp_rd(a)); end
    end
  endtask

  task automatic test_fifo_overflow();
    tx_ready = 1'b0;
    for (int b = 8'h41; b <= 8'h45; b++) begin
      bus(1'b1, 32'h8000_0008, 32'(b));
      tick();
    end
    bus(1'b0, 32'h8000_000C, 32'h0); #1;
    n_cmp++; if (readdata !== 32'h6) begin n_bad++; $display("FAIL ovf_status: got %h want 6", readdata); end
    n_cmp++; if (tx_data !== 8'h41 || tx_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_head: got %h/%b want 41/1", tx_data, tx_valid); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        n_bad++; $display("FAIL ovf_drain%0d: got %h/%b want %h/1", i, tx_data, tx_valid, 8'(8'h41 + i));
      end
      tick();
    end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty: got %b want 0", tx_valid); end
    n_cmp++; if (readdata !== 32'h5) begin n_bad++; $display("FAIL ovf_status_empty: got %h want 5", readdata); end
    bus(1'b1, 32'h8000_000C, 32'h4);
    tick();
    memwrite = 1'b0; #1;
    n_cmp++; if (readdata !== 32'h1) begin n_bad++; $display("FAIL ovf_clear: got %h want 1", readdata); end
  endtask

  task automatic test_full_pop_push();
    byte unsigned exp[4];
    int got;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp[i] = 8'($urandom_range(0, 255));
      bus(1'b1, 32'h8000_0008, {24'h0, exp[i]});
      tick();
    end
    bus(1'b0, 32'h8000_000C, 32'h0); #1;
    n_cmp++; if (readdata !== 32'h2) begin n_bad++; $display("FAIL fpp_full: got %h want 2", readdata); end
    tx_ready = 1'b1;
    bus(1'b1, 32'h8000_0008, 32'h55);
    tick();
    bus(1'b0, 32'h8000_000C, 32'h0); #1;
    n_cmp++; if (readdata !== 32'h2) begin n_bad++; $display("FAIL fpp_no_ovf: got %h want 2", readdata); end
    exp[0] = exp[1]; exp[1] = exp[2]; exp[2] = exp[3]; exp[3] = 8'h55;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      if (tx_valid && got < 4) begin
        n_cmp++; if (tx_data !== exp[got]) begin n_bad++; $display("FAIL fpp_seq%0d: got %h want %h", got, tx_data, exp[got]); end
        got++;
      end
      tick();
    end
    n_cmp++; if (got !== 4 || tx_valid !== 1'b0) begin n_bad++; $display("FAIL fpp_count: got %0d bytes valid=%b want 4 bytes valid=0", got, tx_valid); end
  endtask

  task automatic test_bus_err();
    logic [7:0] led_before;
    logic [31:0] st_before;
    led_before = m_led;
    st_before = exp_rd(32'h8000_000C);
    bus(1'b1, 32'h8000_0040, 32'h1234);
    tick();
    bus(1'b0, 32'h8000_000C, 32'h0); #1;
    n_cmp++; if (bus_err !== 1'b1) begin n_bad++; $display("FAIL berr_set: got %b want 1", bus_err); end
    n_cmp++; if (led !== led_before) begin n_bad++; $display("FAIL berr_led: got %h want %h", led, led_before); end
    n_cmp++; if (readdata !== st_before) begin n_bad++; $display("FAIL berr_status: got %h want %h", readdata, st_before); end
    aluout = 32'h0000_0040; #1;
    if (rd_known(aluout)) begin
      n_cmp++; if (readdata !== exp_rd(aluout)) begin n_bad++; $display("FAIL berr_ram: got %h want %h", readdata, exp_rd(aluout)); end
    end
    bus(1'b1, 32'h8000_0000, 32'hA5);
    tick();
    memwrite = 1'b0; #1;
    n_cmp++; if (led !== 8'hA5) begin n_bad++; $display("FAIL led_write: got %h want a5", led); end
    n_cmp++; if (bus_err !== 1'b1) begin n_bad++; $display("FAIL berr_sticky: got %b want 1", bus_err); end
  endtask

  task automatic test_random();
    logic [31:0] r, a;
    int op;
    for (int c = 0; c < 300; c++) begin
      r = $urandom();
      op = $urandom_range(0, 19);
      tx_ready = ($urandom_range(0, 2) == 0);
      case (op)
        0, 1, 2:  bus(1'b1, {1'b0, r[30:0]}, $urandom());
        3, 4, 5:  bus(1'b0, {1'b0, r[30:0]}, $urandom());
        6:        bus(1'b1, {1'b1, r[30:8], 6'd0, r[1:0]}, $urandom());
        7, 8, 9:  bus(1'b1, {1'b1, r[30:8], 6'd2, r[1:0]}, $urandom());
        10:       bus(1'b1, {1'b1, r[30:8], 6'd3, r[1:0]}, $urandom());
        11:       bus(1'b1, {1'b1, r[30:8], 6'(r[7:2] | 6'd4), r[1:0]}, $urandom());
        12:       bus(1'b1, {1'b1, r[30:8], 6'd1, r[1:0]}, $urandom());
        default:  bus(1'b0, {1'b1, r[30:8], 6'(r[3:2]), r[1:0]}, $urandom());
      endcase
      a = aluout;
      #1;
      if (rd_known(a)) begin
        n_cmp++; if (readdata !== exp_rd(a)) begin n_bad++; $display("FAIL rand_rd c%0d: addr %h got %h want %h", c, a, readdata, exp_rd(a)); end
      end
      n_cmp++; if (led !== m_led) begin n_bad++; $display("FAIL rand_led c%0d: got %h want %h", c, led, m_led); end
      n_cmp++; if (tx_valid !== (m_q.size() > 0)) begin n_bad++; $display("FAIL rand_valid c%0d: got %b want %b", c, tx_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        n_cmp++; if (tx_data !== m_q[0]) begin n_bad++; $display("FAIL rand_data c%0d: got %h want %h", c, tx_data, m_q[0]); end
      end
      n_cmp++; if (bus_err !== m_berr) begin n_bad++; $display("FAIL rand_berr c%0d: got %b want %b", c, bus_err, m_berr); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ram_exp;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus(1'b1, 32'h8000_0008, 32'(8'h60 + i));
      tick();
    end
    bus(1'b1, 32'h8000_0000, 32'h3C);
    tick();
    bus(1'b0, 32'h0000_0010, 32'h0);
    tx_ready = 1'b1;
    tick();
    n_cmp++; if (tx_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid: got %b want 1", tx_valid); end
    ram_exp = exp_rd(32'h0000_0010);
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", tx_valid); end
    n_cmp++; if (led !== 8'h00) begin n_bad++; $display("FAIL mid_led: got %h want 00", led); end
    n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL mid_berr: got %b want 0", bus_err); end
    aluout = 32'h8000_0004; #1;
    n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL mid_cycle: got %h want 0", readdata); end
    aluout = 32'h0000_0010; #1;
    n_cmp++; if (readdata !== ram_exp) begin n_bad++; $display("FAIL mid_ram: got %h want %h", readdata, ram_exp); end
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    n_cmp++; if (readdata !== ram_exp) begin n_bad++; $display("FAIL post_ram: got %h want %h", readdata, ram_exp); end
  endtask

  initial begin
    test_reset();
    test_cycle();
    test_ram();
    test_fifo_overflow();
    test_full_pop_push();
    test_bus_err();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
